// File: rtl/ft_tx_packetizer_if.sv
// Framed output stream toward the FT600 write path: valid/ready handshake
// with start/end-of-packet markers.
interface ft_tx_packetizer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_sop;
  logic                  out_eop;

  modport master (
    output out_valid,
    output out_data,
    output out_sop,
    output out_eop,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_sop,
    input  out_eop,
    output out_ready
  );
endinterface

// File: rtl/ft_tx_packetizer.sv
// Round-robin merge of per-channel sample FIFOs into header+payload packets,
// with per-channel sequence numbers and a 2-entry payload skid buffer.
module ft_tx_packetizer #(
  parameter int DATA_WIDTH    = 32,
  parameter int IQ_PAIR_WIDTH = 24,
  parameter int CHANNELS      = 2,
  parameter int PKT_WORDS     = 32,
  parameter int SEQ_WIDTH     = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [CHANNELS-1:0]               ch_enough,
  input  logic [CHANNELS-1:0]               ch_empty,
  output logic [CHANNELS-1:0]               ch_rd,
  input  logic [CHANNELS*IQ_PAIR_WIDTH-1:0] ch_data,
  ft_tx_packetizer_if.master                out_if,
  output logic                              busy,
  output logic                              underrun
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = $clog2(PKT_WORDS + 1);

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  state_t                   state_reg, state_next;
  logic [CH_W-1:0]          grant_reg, grant_next, rr_reg;
  logic [SEQ_WIDTH-1:0]     seq_reg [CHANNELS];
  logic [CNT_W-1:0]         issued_reg, sent_reg;
  logic [1:0]               occ_reg;
  logic                     inflight_reg;
  logic [IQ_PAIR_WIDTH-1:0] skid_reg [2];
  logic                     underrun_reg;

  logic [CH_W:0]            cand;
  logic                     found;
  logic [IQ_PAIR_WIDTH-1:0] rd_sample, head_sample;
  logic                     active, pay_valid, pop, last_word, pay_done, rd_en;
  logic                     buf_pop, bypass, wr_idx;
  logic [2:0]               occ_after;
  logic [31:0]              header;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      grant_reg <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
    end
  end

  // Next-state logic, including the round-robin grant search from rr_reg
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    found      = 1'b0;
    cand       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = (CH_W+1)'(rr_reg) + (CH_W+1)'(i);
      if (cand >= (CH_W+1)'(CHANNELS))
        cand = cand - (CH_W+1)'(CHANNELS);
      if (!found && ch_enough[cand[CH_W-1:0]]) begin
        found      = 1'b1;
        grant_next = cand[CH_W-1:0];
      end
    end
    case (state_reg)
      IDLE: begin
        if (enable && found) state_next = HDR;
        else                 grant_next = grant_reg;
      end
      HDR: begin
        grant_next = grant_reg;
        if (out_if.out_ready) state_next = PAY;
      end
      PAY: begin
        grant_next = grant_reg;
        if (pay_done) state_next = IDLE;
      end
      default: begin
        grant_next = grant_reg;
        state_next = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    rd_sample   = ch_data[grant_reg*IQ_PAIR_WIDTH +: IQ_PAIR_WIDTH];
    // An empty skid buffer forwards the word arriving from the FIFO this cycle
    head_sample = (occ_reg != 2'd0) ? skid_reg[0] : rd_sample;
    active      = (state_reg == HDR) || (state_reg == PAY);
    pay_valid   = (state_reg == PAY) && ((occ_reg != 2'd0) || inflight_reg);
    pop         = pay_valid && out_if.out_ready;
    last_word   = (sent_reg == CNT_W'(PKT_WORDS - 1));
    pay_done    = pop && last_word;
    occ_after   = {1'b0, occ_reg} + {2'b0, inflight_reg} - {2'b0, pop};
    rd_en       = active && (issued_reg < CNT_W'(PKT_WORDS)) &&
                  !ch_empty[grant_reg] && (occ_after < 3'd2);
    ch_rd            = '0;
    ch_rd[grant_reg] = rd_en;
    header = {8'hA5, 8'(grant_reg), 8'(seq_reg[grant_reg]), 8'(PKT_WORDS - 1)};

    out_if.out_valid = (state_reg == HDR) || pay_valid;
    out_if.out_data  = '0;
    out_if.out_sop   = 1'b0;
    out_if.out_eop   = 1'b0;
    if (state_reg == HDR) begin
      out_if.out_data = DATA_WIDTH'(header);
      out_if.out_sop  = 1'b1;
    end else if (pay_valid) begin
      out_if.out_data = DATA_WIDTH'(head_sample);
      out_if.out_eop  = last_word;
    end
    busy     = active;
    underrun = underrun_reg;

    buf_pop = pop && (occ_reg != 2'd0);
    bypass  = pop && (occ_reg == 2'd0);
    wr_idx  = 1'(occ_reg - {1'b0, buf_pop});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_reg       <= '0;
      issued_reg   <= '0;
      sent_reg     <= '0;
      occ_reg      <= '0;
      inflight_reg <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      inflight_reg <= rd_en;
      occ_reg      <= occ_after[1:0];
      if (rd_en) issued_reg <= issued_reg + 1'b1;
      if (pop)   sent_reg   <= sent_reg + 1'b1;
      if (active && (issued_reg < CNT_W'(PKT_WORDS)) && ch_empty[grant_reg])
        underrun_reg <= 1'b1;
      if (pay_done) begin
        issued_reg <= '0;
        sent_reg   <= '0;
        rr_reg     <= (grant_reg == CH_W'(CHANNELS - 1)) ? '0 : grant_reg + 1'b1;
      end
    end
  end

  // Skid storage needs no reset: occ_reg alone marks entries valid
  always_ff @(posedge clk) begin
    if (buf_pop) skid_reg[0] <= skid_reg[1];
    if (inflight_reg && !bypass) skid_reg[wr_idx] <= rd_sample;
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_seq
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          seq_reg[gi] <= '0;
        else if (pay_done && (grant_reg == CH_W'(gi)))
          seq_reg[gi] <= seq_reg[gi] + 1'b1;
      end
    end
  endgenerate
endmodule

// File: tb/tb_ft_tx_packetizer.sv
// Directed/randomized bench for ft_tx_packetizer with FIFO models and a
// packet-level reference model of the round-robin framing rules.
module tb_ft_tx_packetizer;
  localparam int DW = 32, IW = 24, CH = 2, PW = 4, SW = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [CH-1:0]     ch_enough, ch_empty, ch_rd;
  logic [CH*IW-1:0]  ch_data;
  logic              busy, underrun;
  logic [CH-1:0]     force_empty = '0;

  ft_tx_packetizer_if #(.DATA_WIDTH(DW)) sif();

  ft_tx_packetizer #(
    .DATA_WIDTH(DW), .IQ_PAIR_WIDTH(IW), .CHANNELS(CH), .PKT_WORDS(PW), .SEQ_WIDTH(SW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .ch_enough(ch_enough), .ch_empty(ch_empty), .ch_rd(ch_rd), .ch_data(ch_data),
    .out_if(sif.master), .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Channel FIFO models: ring storage, Q registered one cycle after ch_rd
  logic [IW-1:0] mem [CH][4096];
  int            pushed [CH] = '{0, 0};
  int            popped [CH] = '{0, 0};
  logic [IW-1:0] q_reg  [CH];

  always @(posedge clk) begin
    for (int k = 0; k < CH; k++) begin
      if (ch_rd[k]) begin
        q_reg[k]  <= mem[k][popped[k] % 4096];
        popped[k] <= popped[k] + 1;
      end
    end
  end

  always_comb begin
    ch_enough = '0;
    ch_empty  = '0;
    ch_data   = '0;
    for (int k = 0; k < CH; k++) begin
      ch_enough[k]         = (pushed[k] - popped[k]) >= PW;
      ch_empty[k]          = (pushed[k] == popped[k]) || force_empty[k];
      ch_data[k*IW +: IW]  = q_reg[k];
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected payload per channel, in push order
  logic [IW-1:0] ref0 [$];
  logic [IW-1:0] ref1 [$];

  task automatic push(input int k, input logic [IW-1:0] v);
    mem[k][pushed[k] % 4096] = v;
    pushed[k] = pushed[k] + 1;
    if (k == 0) ref0.push_back(v);
    else        ref1.push_back(v);
  endtask

  // Transfer log and reference-model state
  logic [DW-1:0] log_data [$];
  bit            log_eop  [$];
  int            log_cyc  [$];
  logic [31:0]   hdr_log  [$];
  int            cyc = 0, rr_m = 0, cur_ch = 0, wcount = 0, rd_cnt = 0, pkt_done = 0;
  int            seq_m [CH];
  bit            act = 0, prev_valid = 0, prev_stall = 0, prev_sop = 0, prev_eop = 0;
  logic [DW-1:0] prev_data;
  logic [CH-1:0] prev_enough = '0;

  always @(negedge clk) begin
    logic [CH-1:0] mask;
    logic [IW-1:0] exp_w;
    logic [31:0]   exp_h;
    int            e;
    bit            found;
    cyc++;
    if (reset) begin
      rr_m = 0; act = 0; wcount = 0; rd_cnt = 0; prev_stall = 0; prev_valid = 0;
      for (int k = 0; k < CH; k++) seq_m[k] = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", sif.out_valid, 1);
        chk("hold_data", sif.out_data, prev_data);
        chk("hold_sop", sif.out_sop, prev_sop);
        chk("hold_eop", sif.out_eop, prev_eop);
      end
      if (sif.out_valid && sif.out_sop && !prev_valid) begin
        found = 0; e = 0;
        for (int i = 0; i < CH; i++)
          if (!found && prev_enough[(rr_m + i) % CH]) begin found = 1; e = (rr_m + i) % CH; end
        chk("grant_found", found, 1);
        cur_ch = e; act = 1; wcount = 0; rd_cnt = 0;
      end
      rd_cnt += $countones(ch_rd);
      mask = act ? CH'(1 << cur_ch) : '0;
      chk("rd_grant", ch_rd & ~mask, 0);
      if (sif.out_valid && sif.out_ready) begin
        log_data.push_back(sif.out_data);
        log_eop.push_back(sif.out_eop);
        log_cyc.push_back(cyc);
        if (sif.out_sop) begin
          exp_h = {8'hA5, 8'(cur_ch), 8'(seq_m[cur_ch]), 8'(PW - 1)};
          chk("header", sif.out_data, exp_h);
          hdr_log.push_back(sif.out_data);
        end else begin
          exp_w = 'x;
          if (cur_ch == 0 && ref0.size() > 0) exp_w = ref0.pop_front();
          if (cur_ch == 1 && ref1.size() > 0) exp_w = ref1.pop_front();
          chk("payload", sif.out_data, DW'(exp_w));
          chk("eop", sif.out_eop, wcount == PW - 1);
          wcount++;
          if (sif.out_eop) begin
            chk("rd_per_pkt", rd_cnt, PW);
            seq_m[cur_ch] = (seq_m[cur_ch] + 1) % (1 << SW);
            rr_m = (cur_ch + 1) % CH;
            act = 0;
            pkt_done++;
          end
        end
      end
      prev_stall = sif.out_valid && !sif.out_ready;
      prev_data  = sif.out_data;
      prev_sop   = sif.out_sop;
      prev_eop   = sif.out_eop;
      prev_valid = sif.out_valid;
    end
    prev_enough = ch_enough;
  end

  int rmode = 0;

  task automatic step();
    @(posedge clk); #1;
    case (rmode)
      0:       sif.out_ready = 1'b1;
      1:       sif.out_ready = ~sif.out_ready;
      default: sif.out_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic wait_pkts(input int n, input int budget);
    int tgt = pkt_done + n;
    int c = 0;
    while (pkt_done < tgt && c < budget) begin step(); c++; end
    chk("pkt_timeout", pkt_done >= tgt, 1);
  endtask

  task automatic clear_logs();
    log_data.delete(); log_eop.delete(); log_cyc.delete(); hdr_log.delete();
  endtask

  task automatic clear_fifos();
    for (int k = 0; k < CH; k++) pushed[k] = popped[k];
    ref0.delete(); ref1.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, sif.out_valid, 0);
    chk({tag, "_data"}, sif.out_data, 0);
    chk({tag, "_sop"}, sif.out_sop, 0);
    chk({tag, "_eop"}, sif.out_eop, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_underrun"}, underrun, 0);
    chk({tag, "_rd"}, ch_rd, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    force_empty = '0;
    repeat (2) @(posedge clk);
    #1;
    clear_fifos();
    clear_logs();
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    sif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    step();
    check_zero("idle");

    // Single packet on channel 0, samples 1..4, ready held high
    clear_logs();
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) push(0, IW'(i));
    wait_pkts(1, 50);
    chk("t1_len", log_data.size(), 5);
    if (log_data.size() == 5) begin
      chk("t1_hdr", log_data[0], 32'hA5000003);
      for (int i = 1; i <= 4; i++) begin
        chk("t1_word", log_data[i], i);
        chk("t1_cycle", log_cyc[i], log_cyc[0] + i);
        chk("t1_eopflag", log_eop[i], i == 4);
      end
    end
    chk("t1_underrun", underrun, 0);

    // Underrun after two payload reads; completion after release
    clear_logs();
    for (int i = 0; i < 4; i++) push(0, IW'($urandom));
    c = 0;
    while (!(act && rd_cnt >= 2) && c < 20) begin step(); c++; end
    chk("t5_reads_seen", act && rd_cnt >= 2, 1);
    force_empty[0] = 1'b1;
    repeat (5) step();
    chk("t5_valid_low", sif.out_valid, 0);
    chk("t5_underrun", underrun, 1);
    chk("t5_busy", busy, 1);
    chk("t5_drained", log_data.size(), 3);
    force_empty[0] = 1'b0;
    wait_pkts(1, 50);
    chk("t5_len", log_data.size(), 5);
    if (hdr_log.size() > 0) chk("t5_hdr", hdr_log[0], 32'hA5000103);
    if (log_eop.size() == 5) chk("t5_eop", log_eop[4], 1);

    // Alternating back-pressure on channel 1
    clear_logs();
    rmode = 1;
    for (int i = 0; i < 4; i++) push(1, IW'($urandom));
    wait_pkts(1, 60);
    rmode = 0;
    step();
    chk("t3_len", log_data.size(), 5);
    if (hdr_log.size() > 0) chk("t3_hdr", hdr_log[0], 32'hA5010003);

    // Both channels continuously enough: order 0,1,0,1
    do_reset();
    for (int i = 0; i < 8; i++) begin push(0, IW'($urandom)); push(1, IW'($urandom)); end
    wait_pkts(4, 100);
    chk("t2_count", hdr_log.size(), 4);
    if (hdr_log.size() >= 4) begin
      chk("t2_hdr0", hdr_log[0], 32'hA5000003);
      chk("t2_hdr1", hdr_log[1], 32'hA5010003);
      chk("t2_hdr2", hdr_log[2], 32'hA5000103);
      chk("t2_hdr3", hdr_log[3], 32'hA5010103);
    end

    // Sequence wrap: 257 packets on channel 1 with random ready
    do_reset();
    rmode = 2;
    for (int i = 0; i < 257 * PW; i++) push(1, IW'($urandom));
    wait_pkts(257, 257 * 30);
    rmode = 0;
    step();
    chk("t4_count", hdr_log.size(), 257);
    if (hdr_log.size() >= 257) begin
      chk("t4_seq255", hdr_log[255][15:8], 8'hFF);
      chk("t4_wrap", hdr_log[256], 32'hA5010003);
    end

    // Reset in the middle of a packet
    clear_logs();
    for (int i = 0; i < 4; i++) push(0, IW'($urandom));
    c = 0;
    while (log_data.size() < 2 && c < 20) begin step(); c++; end
    chk("t6_in_pay", log_data.size() >= 2, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    clear_fifos();
    clear_logs();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) push(1, IW'($urandom));
    wait_pkts(1, 50);
    chk("t6_len", log_data.size(), 5);
    if (hdr_log.size() > 0) chk("t6_hdr", hdr_log[0], 32'hA5010003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ft_tx_packetizer.md
Name: ft_tx_packetizer

Overview:
- Merges CHANNELS receive-sample FIFOs into framed packets on a single stream toward the FT600 write path. This generalises the single-channel a2f path.
- Each packet is one header word followed by PKT_WORDS payload words from one channel.
- Channels are served round-robin, with a per-channel sequence number so the host can detect drops.
- Sits between the per-channel a2f FIFO read ports and the FT600 FSM write interface, in the ft_clk domain.

Parameters:
- DATA_WIDTH, 32, output word width; must be >= 32 and >= IQ_PAIR_WIDTH.
- IQ_PAIR_WIDTH, 24, width of one IQ sample pair from a channel FIFO.
- CHANNELS, 2, number of input channels; range 1..16.
- PKT_WORDS, 32, payload words per packet; range 2..256.
- SEQ_WIDTH, 8, width of the per-channel sequence counter; must be <= 8.

Ports:
- clk, in, 1: ft_clk domain clock.
- reset, in, 1: asynchronous, active-high reset.
- enable, in, 1: allow new packets to start.
- ch_enough, in, CHANNELS: channel FIFO holds >= PKT_WORDS words.
- ch_empty, in, CHANNELS: channel FIFO empty.
- ch_rd, out, CHANNELS: FIFO read strobe, one-hot or zero. Data is valid 1 cycle after the strobe.
- ch_data, in, CHANNELS*IQ_PAIR_WIDTH: FIFO Q buses; channel k occupies [k*IQ_PAIR_WIDTH +: IQ_PAIR_WIDTH].
- out_valid, out, 1: out_data valid.
- out_ready, in, 1: sink accepts the word; a transfer happens when out_valid && out_ready.
- out_data, out, DATA_WIDTH: header or payload word.
- out_sop, out, 1: current word is the header.
- out_eop, out, 1: current word is the last payload word.
- busy, out, 1: a packet is in progress.
- underrun, out, 1: sticky; a granted channel went empty mid-packet.

Behaviour:
- Reset state: every output 0. State IDLE. Round-robin pointer 0. All sequence counters 0. Skid buffer empty.
- Header word layout:
  - bits [31:24] = 8'hA5.
  - bits [23:16] = channel index.
  - bits [15:8] = seq, zero-extended.
  - bits [7:0] = PKT_WORDS-1, truncated to 8 bits.
  - bits above 31 are 0.
- Payload word: {zeros, IQ pair}, with the sample in the low IQ_PAIR_WIDTH bits.
- IDLE:
  - Leaves IDLE when enable=1 and any ch_enough bit is set.
  - Grant goes to the first channel with ch_enough set, searching upward from the round-robin pointer and wrapping.
  - The grant is registered; the next state is HDR.
- HDR:
  - out_valid=1 and out_sop=1, carrying the header.
  - The header is held stable until out_ready.
  - The first ch_rd for the granted channel is issued in the first HDR cycle as a prefetch.
  - On header transfer, the next state is PAY.
- PAY:
  - Streams exactly PKT_WORDS words.
  - Payload goes through a 2-entry skid buffer.
  - ch_rd is asserted only when all of the following hold: words_issued < PKT_WORDS, the granted channel's ch_empty=0, and (occupancy + in-flight reads - pop this cycle) < 2.
  - With out_ready held at 1, payload words appear on consecutive cycles with no bubbles.
  - out_eop=1 accompanies word PKT_WORDS-1.
  - On that word's transfer:
    - the granted channel's seq increments, wrapping from 2^SEQ_WIDTH-1 to 0;
    - the round-robin pointer becomes grant+1 mod CHANNELS;
    - state returns to IDLE.
- Back-pressure: while out_valid=1 and out_ready=0, out_data, out_sop and out_eop hold unchanged.
- Packet spacing: a new header may appear no earlier than 1 cycle after the previous eop transfer, because IDLE lasts 1 cycle.
- Underrun:
  - If the granted ch_empty=1 while reads are still owed, no read is issued and the FSM stalls with out_valid=0 once the buffer drains.
  - underrun is set and stays set until reset.
  - The packet completes when data resumes; no words are dropped or padded.
- enable deasserted mid-packet: the current packet completes normally, then the block stays in IDLE.
- Reset mid-packet: the asynchronous return to the reset state occurs immediately; a partial packet is abandoned.
- busy = 1 in HDR and PAY.
- Only one bit of ch_rd is ever asserted, and only for the granted channel.

Test Plan:
- CHANNELS=2, PKT_WORDS=4, channel 0 enough with samples 1..4, out_ready=1 -> header 0xA5000003, then 0x1,0x2,0x3,0x4 on 4 consecutive cycles, eop on 0x4, channel 0 seq becomes 1.
- Both channels enough continuously -> packet channel order 0,1,0,1. The third header is 0xA5000103 and the fourth is 0xA5010103.
- out_ready toggled 1/0 each cycle during payload -> words held stable while stalled, no duplicates or losses; ch_rd count equals exactly 4 per packet.
- 256 packets on channel 1 with SEQ_WIDTH=8 -> the 257th header carries seq 0x00 (wrap).
- ch_empty forced to 1 after 2 payload words -> out_valid drops after the buffered words drain, underrun=1; releasing ch_empty lets the remaining 2 words complete with eop.
- Assert reset in the middle of PAY -> all outputs 0 immediately. After release with channel 1 enough, the first packet comes from channel 1 with seq 0.
